// File: rtl/sprite_sched_if.sv
// Sprite scheduler bus: display position, host config port, engine start/x
// outputs and the merged pixel-select.
interface sprite_sched_if #(
  parameter int unsigned NSPR  = 4,
  parameter int unsigned CORDW = 10,
  parameter int unsigned IDW   = $clog2(NSPR)
);
  logic [CORDW-1:0]      sx;
  logic [CORDW-1:0]      sy;
  logic                  cfg_we;
  logic [IDW-1:0]        cfg_id;
  logic [CORDW-1:0]      cfg_x;
  logic [CORDW-1:0]      cfg_y;
  logic                  cfg_en;
  logic                  cfg_pending;
  logic                  frame_commit;
  logic [NSPR-1:0]       spr_start;
  logic [NSPR*CORDW-1:0] spr_x;
  logic [NSPR-1:0]       spr_pix;
  logic                  pix_valid;
  logic [IDW-1:0]        pix_id;

  modport master (
    output sx, sy, cfg_we, cfg_id, cfg_x, cfg_y, cfg_en, spr_pix,
    input  cfg_pending, frame_commit, spr_start, spr_x, pix_valid, pix_id
  );

  modport slave (
    input  sx, sy, cfg_we, cfg_id, cfg_x, cfg_y, cfg_en, spr_pix,
    output cfg_pending, frame_commit, spr_start, spr_x, pix_valid, pix_id
  );
endinterface

// File: rtl/sprite_sched.sv
// Sprite scheduler: shadow/active sprite config committed once per frame in
// vertical blanking, per-engine line-start pulses and priority pixel merge.
module sprite_sched #(
  parameter int unsigned NSPR       = 4,
  parameter int unsigned CORDW      = 10,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned V_RES_FULL = 525,
  parameter int unsigned IDW        = $clog2(NSPR)
) (
  input  logic          clk,
  input  logic          rst_n,
  sprite_sched_if.slave bus
);
  localparam bit ID_FULL = (NSPR == (2 ** IDW));

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             en;
  } spr_cfg_t;

  typedef enum logic [1:0] {ST_ACTIVE, ST_COMMIT, ST_VBLANK} frame_st_t;

  spr_cfg_t              shadow [NSPR];
  spr_cfg_t              active [NSPR];
  frame_st_t             state;

  logic                  commit_c;
  logic                  wrap_c;
  logic                  wr_ok_c;
  logic [NSPR-1:0]       start_c;
  logic [NSPR-1:0]       hit_c;
  logic [IDW-1:0]        win_c;
  logic [CORDW-1:0]      y_cor_c;
  logic [NSPR*CORDW-1:0] spr_x_c;

  // Ids beyond the populated engines are dropped without touching pending.
  if (ID_FULL) begin : g_id_full
    assign wr_ok_c = bus.cfg_we;
  end else begin : g_id_part
    assign wr_ok_c = bus.cfg_we && (bus.cfg_id < IDW'(NSPR));
  end

  // Frame position decode, start-line match and lowest-index-wins merge.
  always_comb begin
    commit_c = (bus.sy == CORDW'(V_RES)) && (bus.sx == '0);
    wrap_c   = (bus.sy == '0) && (bus.sx == '0);
    start_c  = '0;
    hit_c    = '0;
    win_c    = '0;
    spr_x_c  = '0;
    y_cor_c  = '0;
    for (int i = 0; i < int'(NSPR); i++) begin
      // Sprite on line y starts during the previous line's blanking.
      y_cor_c = (active[i].y == '0) ? CORDW'(V_RES_FULL - 1) : active[i].y - CORDW'(1);
      start_c[i] = active[i].en && (active[i].y < CORDW'(V_RES_FULL)) &&
                   (bus.sy == y_cor_c) && (bus.sx == CORDW'(H_RES));
      hit_c[i]   = bus.spr_pix[i] && active[i].en;
      spr_x_c[i*CORDW +: CORDW] = active[i].x;
    end
    for (int i = int'(NSPR) - 1; i >= 0; i--) begin
      if (hit_c[i]) win_c = IDW'(i);
    end
  end

  assign bus.spr_x = spr_x_c;

  // Frame tracking, config commit and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_VBLANK;
      for (int i = 0; i < int'(NSPR); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      bus.cfg_pending  <= 1'b0;
      bus.frame_commit <= 1'b0;
      bus.spr_start    <= '0;
      bus.pix_valid    <= 1'b0;
      bus.pix_id       <= '0;
    end else begin
      case (state)
        ST_ACTIVE: if (commit_c) state <= ST_COMMIT;
        ST_COMMIT: state <= ST_VBLANK;
        ST_VBLANK: begin
          if (commit_c)    state <= ST_COMMIT;
          else if (wrap_c) state <= ST_ACTIVE;
        end
        default:   state <= ST_VBLANK;
      endcase

      bus.frame_commit <= commit_c;
      if (commit_c) begin
        for (int i = 0; i < int'(NSPR); i++) active[i] <= shadow[i];
        bus.cfg_pending <= 1'b0;
      end
      // A write on the commit cycle lands after the copy; set beats clear.
      if (wr_ok_c) begin
        shadow[bus.cfg_id] <= '{x: bus.cfg_x, y: bus.cfg_y, en: bus.cfg_en};
        bus.cfg_pending    <= 1'b1;
      end

      bus.spr_start <= start_c;
      bus.pix_valid <= |hit_c;
      bus.pix_id    <= win_c;
    end
  end
endmodule

// File: tb/tb_sprite_sched.sv
// Bench for sprite_sched: directed frame scenarios plus randomized positions,
// writes and pixel patterns compared against a frame-level reference model.
module tb_sprite_sched;
  localparam int unsigned NSPR       = 4;
  localparam int unsigned CORDW      = 10;
  localparam int unsigned IDW        = 2;
  localparam int unsigned H_RES      = 640;
  localparam int unsigned V_RES      = 480;
  localparam int unsigned V_RES_FULL = 525;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_sched_if #(.NSPR(NSPR), .CORDW(CORDW), .IDW(IDW)) bus ();

  sprite_sched #(
    .NSPR(NSPR), .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES),
    .V_RES_FULL(V_RES_FULL), .IDW(IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: shadow and active sprite tables plus expected outputs.
  int sh_x [NSPR], sh_y [NSPR], sh_en [NSPR];
  int ac_x [NSPR], ac_y [NSPR], ac_en [NSPR];
  bit m_pend, m_commit, m_valid;
  bit [NSPR-1:0] m_start;
  int m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic wr(input int id, input int x, input int y, input int en);
    bus.cfg_we = 1'b1;
    bus.cfg_id = IDW'(id);
    bus.cfg_x  = CORDW'(x);
    bus.cfg_y  = CORDW'(y);
    bus.cfg_en = en[0];
  endtask

  // Apply one pixel clock at (x,y), advance the model, then compare outputs.
  task automatic step(input int x, input int y, input int pix);
    bit we, rst;
    int id, wx, wy, wen, line_before;
    bus.sx      = CORDW'(x);
    bus.sy      = CORDW'(y);
    bus.spr_pix = NSPR'(pix);
    we  = bus.cfg_we;
    id  = int'(bus.cfg_id);
    wx  = int'(bus.cfg_x);
    wy  = int'(bus.cfg_y);
    wen = int'(bus.cfg_en);
    rst = !rst_n;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < int'(NSPR); i++) begin
        sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0;
        ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0;
      end
      m_pend = 0; m_commit = 0; m_start = '0; m_valid = 0; m_id = 0;
    end else begin
      m_commit = (y == int'(V_RES)) && (x == 0);
      for (int i = 0; i < int'(NSPR); i++) begin
        line_before = (ac_y[i] == 0) ? int'(V_RES_FULL) - 1 : ac_y[i] - 1;
        m_start[i] = (ac_en[i] != 0) && (ac_y[i] < int'(V_RES_FULL)) &&
                     (y == line_before) && (x == int'(H_RES));
      end
      m_valid = 0;
      m_id    = 0;
      for (int i = 0; i < int'(NSPR); i++) begin
        if (pix[i] && ac_en[i] != 0 && !m_valid) begin
          m_valid = 1;
          m_id    = i;
        end
      end
      if (m_commit) begin
        ac_x = sh_x; ac_y = sh_y; ac_en = sh_en;
        m_pend = 0;
      end
      if (we && id < int'(NSPR)) begin
        sh_x[id] = wx; sh_y[id] = wy; sh_en[id] = wen;
        m_pend = 1;
      end
    end
    #1;
    check("frame_commit", 32'(bus.frame_commit), 32'(m_commit));
    check("cfg_pending",  32'(bus.cfg_pending),  32'(m_pend));
    check("spr_start",    32'(bus.spr_start),    32'(m_start));
    check("pix_valid",    32'(bus.pix_valid),    32'(m_valid));
    check("pix_id",       32'(bus.pix_id),       32'(m_id));
    for (int i = 0; i < int'(NSPR); i++)
      check($sformatf("spr_x[%0d]", i), 32'(bus.spr_x[i*CORDW +: CORDW]), 32'(ac_x[i]));
    bus.cfg_we = 1'b0;
  endtask

  task automatic line(input int y);
    for (int x = 638; x <= 643; x++) step(x, y, int'($urandom));
  endtask

  task automatic commit_frame();
    step(799, 479, int'($urandom));
    step(0, 480, int'($urandom));
    step(1, 480, int'($urandom));
  endtask

  initial begin
    int x, y, k, sel;
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_id = '0; bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_en = 1'b0;
    bus.sx = '0; bus.sy = '0; bus.spr_pix = '0;
    step(5, 5, 0);
    step(6, 5, 15);
    rst_n = 1'b1;

    // Two idle frames: commit pulses, nothing starts or draws.
    for (int f = 0; f < 2; f++) begin
      step(0, 0, 15);
      line(0); line(199); line(524);
      commit_frame();
    end

    // Sprite 0 at (280,200): held in shadow until commit, then starts on line 199.
    step(300, 100, 0);
    wr(0, 280, 200, 1);
    step(301, 100, 1);
    step(302, 100, 1);
    line(199);
    commit_frame();
    line(198); line(199); line(200);

    // y=0 starts on the last line; y=600 never starts, even on an out-of-range line.
    wr(1, 64, 0, 1);   step(10, 300, 0);
    wr(2, 50, 600, 1); step(11, 300, 0);
    commit_frame();
    for (int f = 0; f < 3; f++) begin
      line(524); line(0); line(599); line(199);
      commit_frame();
    end
    // y=525 is just past the frame and must not alias onto line 524.
    wr(2, 50, 525, 1); step(12, 300, 0);
    commit_frame();
    line(524);

    // Write on the commit cycle: copy sees the old shadow, write waits a frame.
    step(799, 479, 0);
    wr(3, 10, 77, 1);
    step(0, 480, 0);
    step(1, 480, 0);
    line(76);
    commit_frame();
    line(76);

    // Priority merge with everything enabled, then with sprite 2 disabled.
    step(100, 50, 'b1110);
    step(101, 50, 'b0001);
    step(102, 50, 'b1000);
    wr(2, 50, 600, 0); step(103, 50, 0);
    commit_frame();
    step(104, 50, 'b0100);
    step(105, 50, 'b1100);

    // Reset mid-frame with sprites enabled: nothing starts until rewrite + commit.
    wr(2, 50, 120, 1); step(106, 50, 0);
    commit_frame();
    line(119);
    step(100, 300, 15);
    rst_n = 1'b0;
    step(101, 300, 15);
    rst_n = 1'b1;
    step(102, 300, 15);
    line(119); line(199); line(524); line(76);
    commit_frame();
    line(119); line(199); line(524);
    wr(0, 5, 1, 1); step(200, 300, 15);
    commit_frame();
    line(0); line(524);

    // Randomized positions, writes and pixels, biased toward interesting points.
    for (int n = 0; n < 2500; n++) begin
      sel = int'($urandom_range(0, 9));
      k   = int'($urandom_range(0, NSPR - 1));
      case (sel)
        0, 1: begin x = int'(H_RES); y = (ac_y[k] == 0) ? 524 : ac_y[k] - 1; end
        2:    begin x = 0;           y = int'(V_RES); end
        3:    begin x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023)); end
        4:    begin x = int'(H_RES); y = int'($urandom_range(0, 524)); end
        default: begin x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524)); end
      endcase
      if ($urandom_range(0, 11) == 0)
        wr(int'($urandom_range(0, NSPR - 1)), int'($urandom_range(0, 639)),
           int'($urandom_range(0, 600)), int'($urandom_range(0, 3) != 0));
      step(x, y, int'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
